// File: rtl/mul.sv
// Combinational WIDTH x WIDTH unsigned array multiplier. The sequencer
// time-multiplexes this block to build a wider product.
module mul #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] c
);

    // Both operands are widened first so the product keeps every bit.
    assign c = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule

// File: rtl/mul16_seq.sv
// 2H x 2H unsigned multiply sequencer. Drives one external H x H multiplier
// with one pair of operand halves per cycle (S0..S3) and accumulates the
// partial products into a 4H-bit result. Handshake: start in, busy/done out.
module mul16_seq #(
    parameter int H = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*H-1:0] op_a,
    input  logic [2*H-1:0] op_b,
    output logic           busy,
    output logic           done,
    output logic [4*H-1:0] p,
    output logic [H-1:0]   mul_a,
    output logic [H-1:0]   mul_b,
    input  logic [2*H-1:0] mul_c
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S0   = 3'd1,
        S1   = 3'd2,
        S2   = 3'd3,
        S3   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [2*H-1:0] ra;
    logic [2*H-1:0] rb;
    logic [4*H-1:0] acc;
    logic [4*H-1:0] c_ext;
    logic           accept;

    // Partial product zero-extended to the accumulator width before shifting.
    assign c_ext  = {{(2*H){1'b0}}, mul_c};

    // A new job is taken only when no job is in flight.
    assign accept = start && ((state == IDLE) || (state == DONE));

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: fixed four-step walk, re-launch from DONE if start is held.
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? S0 : IDLE;
            S0:      state_nxt = S1;
            S1:      state_nxt = S2;
            S2:      state_nxt = S3;
            S3:      state_nxt = DONE;
            DONE:    state_nxt = start ? S0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state register and latched operands only.
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        mul_a = '0;
        mul_b = '0;
        case (state)
            S0: begin
                busy  = 1'b1;
                mul_a = ra[H-1:0];
                mul_b = rb[H-1:0];
            end
            S1: begin
                busy  = 1'b1;
                mul_a = ra[2*H-1:H];
                mul_b = rb[H-1:0];
            end
            S2: begin
                busy  = 1'b1;
                mul_a = ra[H-1:0];
                mul_b = rb[2*H-1:H];
            end
            S3: begin
                busy  = 1'b1;
                mul_a = ra[2*H-1:H];
                mul_b = rb[2*H-1:H];
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: latch operands on accept, accumulate one partial product per
    // step, and publish the product only on the S3 -> DONE edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ra  <= '0;
            rb  <= '0;
            acc <= '0;
            p   <= '0;
        end else if (accept) begin
            ra  <= op_a;
            rb  <= op_b;
            acc <= '0;
        end else begin
            case (state)
                S0:      acc <= acc + c_ext;
                S1, S2:  acc <= acc + (c_ext << H);
                S3:      p   <= acc + (c_ext << (2*H));
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul16_seq.sv
// Bench for mul16_seq paired with the external mul block. Expected products
// go into a queue when a job is launched and are checked when done pulses.
module tb_mul16_seq;

    localparam int H = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2*H-1:0] op_a;
    logic [2*H-1:0] op_b;
    logic           busy;
    logic           done;
    logic [4*H-1:0] p;
    logic [H-1:0]   mul_a;
    logic [H-1:0]   mul_b;
    logic [2*H-1:0] mul_c;

    always #5 clk = ~clk;

    mul16_seq #(.H(H)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .p     (p),
        .mul_a (mul_a),
        .mul_b (mul_b),
        .mul_c (mul_c)
    );

    mul #(.WIDTH(H)) u_mul (
        .a (mul_a),
        .b (mul_b),
        .c (mul_c)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    int          n_checks   = 0;
    int          n_pass     = 0;
    int          n_spurious = 0;
    logic [31:0] sb[$];
    logic [31:0] last_p     = '0;
    logic [31:0] exp_p;
    vec_t        vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding job.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                n_spurious++;
            end else begin
                exp_p = sb.pop_front();
                check("p_on_done", p, exp_p);
                last_p = exp_p;
            end
        end
    end

    // One complete job with start pulsed for a single cycle.
    task automatic run_job(input logic [15:0] a, input logic [15:0] b, input logic [31:0] pexp);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        sb.push_back(pexp);
        @(negedge clk);
        start = 1'b0;
        op_a  = ~a;
        op_b  = ~b;
        for (int s = 0; s < 4; s++) begin
            check("busy_high", 32'(busy), 32'd1);
            check("done_low", 32'(done), 32'd0);
            check("mul_a_step", 32'(mul_a), 32'(s[0] ? a[15:8] : a[7:0]));
            check("mul_b_step", 32'(mul_b), 32'(s[1] ? b[15:8] : b[7:0]));
            check("p_hold", p, last_p);
            @(negedge clk);
        end
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check("mul_a_done", 32'(mul_a), 32'd0);
        check("mul_b_done", 32'(mul_b), 32'd0);
        @(negedge clk);
        check("done_once", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h5678, 32'h0626_0060};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vecs[2] = '{16'h0000, 16'hFFFF, 32'h0000_0000};
        vecs[3] = '{16'h0001, 16'hABCD, 32'h0000_ABCD};
        vecs[4] = '{16'hA1B2, 16'hC3D4, 32'h7BB0_7D68};

        rst   = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_p", p, 32'd0);
        check("rst_mul_a", 32'(mul_a), 32'd0);
        check("rst_mul_b", 32'(mul_b), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_job(vecs[i].a, vecs[i].b, vecs[i].p);
        end

        // start re-asserted mid-job is ignored; held through DONE it
        // launches the next job with no IDLE cycle in between.
        @(negedge clk);
        op_a  = 16'h1234;
        op_b  = 16'h5678;
        start = 1'b1;
        sb.push_back(32'h0626_0060);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        op_a  = 16'h0002;
        op_b  = 16'h0003;
        start = 1'b1;
        check("ign_s1_mul_a", 32'(mul_a), 32'h12);
        check("ign_s1_mul_b", 32'(mul_b), 32'h78);
        @(negedge clk);
        check("ign_s2_mul_a", 32'(mul_a), 32'h34);
        check("ign_s2_mul_b", 32'(mul_b), 32'h56);
        @(negedge clk);
        check("ign_s3_mul_a", 32'(mul_a), 32'h12);
        check("ign_s3_mul_b", 32'(mul_b), 32'h56);
        @(negedge clk);
        check("b2b_done", 32'(done), 32'd1);
        sb.push_back(32'h0000_0006);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done_low", 32'(done), 32'd0);
        check("b2b_mul_a", 32'(mul_a), 32'h02);
        check("b2b_mul_b", 32'(mul_b), 32'h03);
        repeat (4) @(negedge clk);
        check("b2b_done2", 32'(done), 32'd1);
        @(negedge clk);
        check("b2b_idle", 32'(busy), 32'd0);

        // Asynchronous reset in S2 aborts the job without a clock edge.
        @(negedge clk);
        op_a  = 16'h1234;
        op_b  = 16'h5678;
        start = 1'b1;
        sb.push_back(32'h0626_0060);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_abort_busy", 32'(busy), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_p", p, 32'd0);
        check("abort_mul_a", 32'(mul_a), 32'd0);
        check("abort_mul_b", 32'(mul_b), 32'd0);
        sb.delete();
        last_p = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("post_abort_idle", 32'(busy), 32'd0);
        run_job(16'h1234, 16'h5678, 32'h0626_0060);

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("spurious_done", 32'(n_spurious), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
